swap_store_responder: RTL and testbench
=======================================

Name: swap_store_responder

Overview:
- Responder end of the paging filesystem interface. Services the fs* read, write and metadata requests issued by the paged memory on a page miss.
- Backs page contents with an on-chip store and per-page permission metadata with a small table (the /dev/memmeta region).
- Returns read data with fixed one-cycle latency. Tracks which pages were ever written and exposes swap statistics plus a sticky error flag.

Parameters:
- widthad, 32, width of fsAddress.
- width, 32, data word width (fsData/fsQ).
- pagebits, 10, log2 words per page (equals initiator hwwidthad-divsize).
- storewidthad, 14, log2 words in backing store; NPAGES = 2^(storewidthad-pagebits) = 16.
- DEFAULT_META, 4'b0110, metadata returned for never-written pages ({elevated, userRead, userWrite, userExec}).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- fsAccess  in  1  initiator page-miss session active
- fsRden  in  1  read request this cycle
- fsWren  in  1  write request this cycle
- fsMeta  in  1  1: address is a page number in the metadata region; 0: word address in the data region
- fsAddress  in  widthad  word address or page number
- fsData  in  width  write data
- fsQ  out  width  read data, valid the cycle after fsRden sampled
- fsReady  out  1  initialisation complete, requests accepted
- fsError  out  1  sticky error flag
- errClr  in  1  clears fsError
- sessionCount  out  16  saturating count of fsAccess rising edges
- swapOuts  out  16  saturating count of accepted metadata writes
- swapIns  out  16  saturating count of accepted metadata reads

Behaviour:
- Reset (rst_n=0 at posedge):
  - fsQ=0, fsReady=0, fsError=0, all counters 0.
  - FSM enters INIT, metaIdx=0.
- FSM INIT:
  - Each cycle clears the metaValid and pageWritten bits for entry metaIdx, then increments metaIdx.
  - After entry NPAGES-1 moves to IDLE; fsReady=1 from the next cycle. Exactly NPAGES cycles from reset release.
- FSM IDLE: terminal state; only rst_n returns to INIT. Reset mid-INIT restarts the sweep at 0.
- Requests while fsReady=0: ignored, fsQ=0, no error, no counters.
- Data write (fsWren, ~fsMeta, address < 2^storewidthad): store[address] <= fsData; pageWritten[address>>pagebits] <= 1.
- Data read (fsRden, ~fsMeta, in range): next cycle fsQ = store[address] if pageWritten of that page, else 0.
- Data read after write: a read in cycle k+1 of the address written in cycle k returns the new data (write-first forwarding).
- Metadata write (fsWren, fsMeta, page < NPAGES):
  - meta[page] <= fsData[3:0]; metaValid[page] <= 1.
  - Also clears pageWritten[page] only if fsData[31]=1 (explicit page discard); otherwise pageWritten is untouched.
  - swapOuts++.
- Metadata read (fsRden, fsMeta, page < NPAGES):
  - Next cycle fsQ = {28'b0, metaValid ? meta : DEFAULT_META}.
  - swapIns++.
- Out of range (data address >= 2^storewidthad or page >= NPAGES): writes dropped, read fsQ=0, fsError <= 1.
- fsRden and fsWren both high: neither performed, fsQ=0 next cycle, fsError <= 1.
- No request: fsQ holds 0 the following cycle; fsQ never holds stale data.
- errClr: clears fsError; if errClr and a new error occur in the same cycle, the error wins (fsError=1).
- sessionCount: increments on fsAccess 0->1 (registered previous value; the previous value resets to 0).
- Counters: saturate at 16'hFFFF, no wrap.
- Address arithmetic: page = fsAddress >> pagebits for data; fsAddress used directly as page for metadata. Range checks use the full widthad bits.

Decomposition:
- Shared package swap_pkg holds:
  - META_W=4 and the metadata bit positions (elevated=3, userRead=2, userWrite=1, userExec=0);
  - DEFAULT_META;
  - DISCARD_BIT=31;
  - FSM state constants INIT/IDLE.
- One natural sub-module, swap_meta_table: the NPAGES-entry meta/metaValid/pageWritten register file with the sweep-clear port.
- The data store reuses the existing RAM module (single port used).

Test Plan:
- Reset release -> fsReady=0 for exactly 16 cycles, then 1. Reasserting rst_n=0 at cycle 8 -> a fresh 16-cycle sweep.
- Write 0xDEADBEEF to address 0x0412, read 0x0412 the next cycle -> fsQ=0xDEADBEEF one cycle later. Read 0x0800 (never written) -> fsQ=0.
- Metadata read of page 3 before any write -> fsQ=0x6. Metadata write 0xB to page 3, then read -> fsQ=0xB. swapOuts=1, swapIns=2.
- Read address 0x4000 -> fsQ=0 and fsError=1. Assert errClr -> 0. Assert fsRden and fsWren together -> fsError=1 and store unchanged.
- Metadata write 0x80000005 to page 1 after data written to 0x0400 -> reading 0x0400 returns 0 and page 1 metadata reads 0x5.
- Pulse fsAccess 3 times -> sessionCount=3. Force 65536 metadata reads -> swapIns stays 0xFFFF.

Source files
------------

// File: rtl/swap_pkg.sv
// rtl/swap_pkg.sv - shared constants, types and helpers for the swap store responder
package swap_pkg;

    // Metadata word layout: {elevated, userRead, userWrite, userExec}
    localparam int unsigned META_W         = 4;
    localparam int unsigned META_ELEVATED  = 3;
    localparam int unsigned META_USER_RD   = 2;
    localparam int unsigned META_USER_WR   = 1;
    localparam int unsigned META_USER_EXEC = 0;

    // Permissions reported for a page whose metadata was never written
    localparam logic [META_W-1:0] DEFAULT_META = 4'b0110;

    // fsData bit that requests a page discard on a metadata write
    localparam int unsigned DISCARD_BIT = 31;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } swap_state_t;

    // Source of fsQ in the cycle after a request
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_DATA = 2'd1,
        RD_META = 2'd2
    } rd_sel_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/swap_meta_table.sv
// rtl/swap_meta_table.sv - per-page metadata, metaValid and pageWritten register file
//
// Ports:
//   clk             clock
//   clr_en_i        sweep clear: drop metaValid and pageWritten of clr_idx_i
//   clr_idx_i       entry cleared by the sweep
//   idx_i           page addressed by the current request (read and update)
//   meta_we_i       store meta_wdata_i for idx_i and mark it valid
//   meta_wdata_i    permission bits to store
//   discard_i       with meta_we_i: also forget that idx_i was ever written
//   pw_set_i        mark page idx_i as written
//   meta_o          stored permissions of idx_i
//   meta_valid_o    idx_i has had its metadata written
//   page_written_o  idx_i has had data written since the last clear/discard
module swap_meta_table
    import swap_pkg::*;
#(
    parameter int unsigned PAGE_W = 4
) (
    input  logic              clk,
    input  logic              clr_en_i,
    input  logic [PAGE_W-1:0] clr_idx_i,
    input  logic [PAGE_W-1:0] idx_i,
    input  logic              meta_we_i,
    input  logic [META_W-1:0] meta_wdata_i,
    input  logic              discard_i,
    input  logic              pw_set_i,
    output logic [META_W-1:0] meta_o,
    output logic              meta_valid_o,
    output logic              page_written_o
);

    localparam int unsigned NPAGES = 1 << PAGE_W;

    // Permission values need no reset: they are only visible once metaValid is set.
    logic [META_W-1:0] meta_q [NPAGES];
    logic [NPAGES-1:0] meta_valid_q;
    logic [NPAGES-1:0] page_written_q;

    always_ff @(posedge clk) begin
        if (meta_we_i) begin
            meta_q[idx_i] <= meta_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en_i) begin
            meta_valid_q[clr_idx_i]   <= 1'b0;
            page_written_q[clr_idx_i] <= 1'b0;
        end else begin
            if (meta_we_i) begin
                meta_valid_q[idx_i] <= 1'b1;
                if (discard_i) begin
                    page_written_q[idx_i] <= 1'b0;
                end
            end
            if (pw_set_i) begin
                page_written_q[idx_i] <= 1'b1;
            end
        end
    end

    assign meta_o         = meta_q[idx_i];
    assign meta_valid_o   = meta_valid_q[idx_i];
    assign page_written_o = page_written_q[idx_i];

endmodule

// File: rtl/swap_store_ram.sv
// rtl/swap_store_ram.sv - single-port synchronous RAM backing page contents
//
// Ports:
//   clk      clock
//   we_i     write enable
//   addr_i   word address (shared by read and write)
//   wdata_i  write data
//   rdata_o  registered read data of addr_i, one cycle after sampling
module swap_store_ram #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [1 << AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/swap_store_responder.sv
// rtl/swap_store_responder.sv - responder for paging fs read/write/metadata requests
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   fsAccess      initiator page-miss session active (rising edges counted)
//   fsRden/fsWren read / write request this cycle
//   fsMeta        1: fsAddress is a page number in the metadata region
//   fsAddress     word address or page number
//   fsData        write data (bit 31 on metadata writes discards the page)
//   fsQ           read data, valid the cycle after the read is sampled, else 0
//   fsReady       sweep done, requests accepted
//   fsError       sticky error, cleared by errClr (a new error wins)
//   sessionCount, swapOuts, swapIns  saturating statistics
module swap_store_responder
    import swap_pkg::*;
#(
    parameter int unsigned       widthad      = 32,
    parameter int unsigned       width        = 32,
    parameter int unsigned       pagebits     = 10,
    parameter int unsigned       storewidthad = 14,
    parameter logic [META_W-1:0] DEFAULT_META = swap_pkg::DEFAULT_META
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fsAccess,
    input  logic               fsRden,
    input  logic               fsWren,
    input  logic               fsMeta,
    input  logic [widthad-1:0] fsAddress,
    input  logic [width-1:0]   fsData,
    output logic [width-1:0]   fsQ,
    output logic               fsReady,
    output logic               fsError,
    input  logic               errClr,
    output logic [15:0]        sessionCount,
    output logic [15:0]        swapOuts,
    output logic [15:0]        swapIns
);

    localparam int unsigned PAGE_W = storewidthad - pagebits;
    localparam int unsigned NPAGES = 1 << PAGE_W;

    swap_state_t       state_q;
    logic [PAGE_W-1:0] meta_idx_q;
    logic              ready_q;
    rd_sel_t           rd_sel_q;
    logic [META_W-1:0] rd_meta_q;
    logic              err_q, err_d;
    logic              access_prev_q;
    logic [15:0]       sess_q, sess_d;
    logic [15:0]       outs_q, outs_d;
    logic [15:0]       ins_q, ins_d;

    // Request decode. Range checks look at every address bit.
    logic              data_in_range, meta_in_range, in_range;
    logic              req_any, req_both;
    logic              do_wr, do_rd, err_new;
    logic [PAGE_W-1:0] page_idx;

    assign data_in_range = (fsAddress >> storewidthad) == '0;
    assign meta_in_range = (fsAddress >> PAGE_W) == '0;
    assign in_range      = fsMeta ? meta_in_range : data_in_range;
    assign req_any       = fsRden | fsWren;
    assign req_both      = fsRden & fsWren;
    assign do_wr         = ready_q & fsWren & ~fsRden & in_range;
    assign do_rd         = ready_q & fsRden & ~fsWren & in_range;
    assign err_new       = ready_q & (req_both | (req_any & ~in_range));
    assign page_idx      = fsMeta ? fsAddress[PAGE_W-1:0]
                                  : fsAddress[storewidthad-1:pagebits];

    logic [META_W-1:0] tbl_meta;
    logic              tbl_meta_valid;
    logic              tbl_page_written;
    logic [width-1:0]  ram_rdata;

    swap_meta_table #(
        .PAGE_W (PAGE_W)
    ) u_meta_table (
        .clk            (clk),
        .clr_en_i       (state_q == ST_INIT),
        .clr_idx_i      (meta_idx_q),
        .idx_i          (page_idx),
        .meta_we_i      (do_wr & fsMeta),
        .meta_wdata_i   (fsData[META_W-1:0]),
        .discard_i      (fsData[DISCARD_BIT]),
        .pw_set_i       (do_wr & ~fsMeta),
        .meta_o         (tbl_meta),
        .meta_valid_o   (tbl_meta_valid),
        .page_written_o (tbl_page_written)
    );

    // A write lands in the RAM at edge k, so a read sampled at edge k+1 sees it.
    swap_store_ram #(
        .AW (storewidthad),
        .DW (width)
    ) u_store (
        .clk     (clk),
        .we_i    (do_wr & ~fsMeta),
        .addr_i  (fsAddress[storewidthad-1:0]),
        .wdata_i (fsData),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        err_d = err_q;
        if (err_new) begin
            err_d = 1'b1;
        end else if (errClr) begin
            err_d = 1'b0;
        end
        sess_d = (fsAccess & ~access_prev_q) ? sat_inc16(sess_q) : sess_q;
        outs_d = (do_wr & fsMeta) ? sat_inc16(outs_q) : outs_q;
        ins_d  = (do_rd & fsMeta) ? sat_inc16(ins_q) : ins_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            meta_idx_q    <= '0;
            ready_q       <= 1'b0;
            rd_sel_q      <= RD_NONE;
            rd_meta_q     <= '0;
            err_q         <= 1'b0;
            access_prev_q <= 1'b0;
            sess_q        <= '0;
            outs_q        <= '0;
            ins_q         <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    meta_idx_q <= meta_idx_q + PAGE_W'(1);
                    if (meta_idx_q == PAGE_W'(NPAGES - 1)) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase

            // fsQ is rebuilt from these every cycle, so it never holds stale data.
            rd_sel_q <= RD_NONE;
            if (do_rd) begin
                if (fsMeta) begin
                    rd_sel_q  <= RD_META;
                    rd_meta_q <= tbl_meta_valid ? tbl_meta : DEFAULT_META;
                end else if (tbl_page_written) begin
                    rd_sel_q <= RD_DATA;
                end
            end

            err_q         <= err_d;
            access_prev_q <= fsAccess;
            sess_q        <= sess_d;
            outs_q        <= outs_d;
            ins_q         <= ins_d;
        end
    end

    always_comb begin
        fsQ = '0;
        case (rd_sel_q)
            RD_DATA: fsQ = ram_rdata;
            RD_META: fsQ = {{(width - META_W){1'b0}}, rd_meta_q};
            default: fsQ = '0;
        endcase
    end

    assign fsReady      = ready_q;
    assign fsError      = err_q;
    assign sessionCount = sess_q;
    assign swapOuts     = outs_q;
    assign swapIns      = ins_q;

endmodule

// File: tb/tb_swap_store_responder.sv
// tb/tb_swap_store_responder.sv - self-checking bench for swap_store_responder
module tb_swap_store_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fsAccess = 1'b0;
    logic        fsRden = 1'b0;
    logic        fsWren = 1'b0;
    logic        fsMeta = 1'b0;
    logic [31:0] fsAddress = '0;
    logic [31:0] fsData = '0;
    logic [31:0] fsQ;
    logic        fsReady;
    logic        fsError;
    logic        errClr = 1'b0;
    logic [15:0] sessionCount;
    logic [15:0] swapOuts;
    logic [15:0] swapIns;

    swap_store_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fsAccess     (fsAccess),
        .fsRden       (fsRden),
        .fsWren       (fsWren),
        .fsMeta       (fsMeta),
        .fsAddress    (fsAddress),
        .fsData       (fsData),
        .fsQ          (fsQ),
        .fsReady      (fsReady),
        .fsError      (fsError),
        .errClr       (errClr),
        .sessionCount (sessionCount),
        .swapOuts     (swapOuts),
        .swapIns      (swapIns)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the responder remembers, kept as plain arrays.
    logic [31:0] m_store [int unsigned];
    bit          m_written [16];
    logic [3:0]  m_meta [16];
    bit          m_mvalid [16];
    int          m_outs = 0;
    int          m_ins = 0;
    int          m_sess = 0;
    bit          m_err = 0;
    bit          m_ready = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request cycle: drive, predict, clock, compare fsQ and fsError.
    task automatic step(input bit rd, input bit wr, input bit meta,
                        input logic [31:0] addr, input logic [31:0] data, input bit clr);
        logic [31:0] exp_q;
        bit          new_err;
        bit          inr;
        int unsigned pg;
        fsRden = rd; fsWren = wr; fsMeta = meta;
        fsAddress = addr; fsData = data; errClr = clr;
        exp_q = 32'h0;
        new_err = 0;
        if (m_ready && (rd || wr)) begin
            inr = meta ? (addr < 32'd16) : (addr < 32'd16384);
            if (rd && wr) begin
                new_err = 1;
            end else if (!inr) begin
                new_err = 1;
            end else if (wr && meta) begin
                m_meta[addr] = data[3:0];
                m_mvalid[addr] = 1;
                if (data[31]) m_written[addr] = 0;
                if (m_outs < 65535) m_outs++;
            end else if (wr) begin
                m_store[addr] = data;
                m_written[addr / 1024] = 1;
            end else if (meta) begin
                exp_q = m_mvalid[addr] ? {28'h0, m_meta[addr]} : 32'h6;
                if (m_ins < 65535) m_ins++;
            end else begin
                pg = addr / 1024;
                if (m_written[pg] && m_store.exists(addr)) exp_q = m_store[addr];
            end
        end
        if (new_err) m_err = 1;
        else if (clr) m_err = 0;
        @(posedge clk); #1;
        fsRden = 0; fsWren = 0; fsMeta = 0; errClr = 0;
        check("fsQ", fsQ, exp_q);
        check("fsError", {31'h0, fsError}, {31'h0, m_err});
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_swapOuts"}, {16'h0, swapOuts}, m_outs);
        check({tag, "_swapIns"}, {16'h0, swapIns}, m_ins);
        check({tag, "_sessionCount"}, {16'h0, sessionCount}, m_sess);
    endtask

    task automatic pulse_access();
        fsAccess = 1; @(posedge clk); #1;
        fsAccess = 0; @(posedge clk); #1;
        if (m_sess < 65535) m_sess++;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int unsigned kind;

        for (int i = 0; i < 16; i++) begin
            m_written[i] = 0; m_mvalid[i] = 0; m_meta[i] = 4'h0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_fsQ", fsQ, 32'h0);
        check("rst_fsReady", {31'h0, fsReady}, 32'h0);
        check("rst_fsError", {31'h0, fsError}, 32'h0);
        check_counters("rst");

        // Sweep restarted by a reset at cycle 8
        rst_n = 1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("sweep1_ready", {31'h0, fsReady}, 32'h0);
        end
        rst_n = 0;
        @(posedge clk); #1;
        check("midreset_ready", {31'h0, fsReady}, 32'h0);
        rst_n = 1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            check("sweep2_ready", {31'h0, fsReady}, (i == 16) ? 32'h1 : 32'h0);
        end
        m_ready = 1;

        // Data write then immediate read, never-written page
        step(0, 1, 0, 32'h0412, 32'hDEADBEEF, 0);
        step(1, 0, 0, 32'h0412, 32'h0, 0);
        check("raw_value", fsQ, 32'hDEADBEEF);
        step(1, 0, 0, 32'h0800, 32'h0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0);

        // Metadata default, write, read back
        step(1, 0, 1, 32'd3, 32'h0, 0);
        check("meta_default", fsQ, 32'h6);
        step(0, 1, 1, 32'd3, 32'h0000000B, 0);
        step(1, 0, 1, 32'd3, 32'h0, 0);
        check("meta_written", fsQ, 32'hB);
        check("swapOuts_1", {16'h0, swapOuts}, 32'd1);
        check("swapIns_2", {16'h0, swapIns}, 32'd2);

        // Errors: out of range, clear, simultaneous rd/wr, clear vs new error
        step(1, 0, 0, 32'h4000, 32'h0, 0);
        check("oor_err", {31'h0, fsError}, 32'h1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("errclr", {31'h0, fsError}, 32'h0);
        step(1, 1, 0, 32'h0412, 32'h12345678, 0);
        check("both_err", {31'h0, fsError}, 32'h1);
        step(1, 0, 0, 32'h0412, 32'h0, 1);
        check("both_store_kept", fsQ, 32'hDEADBEEF);
        step(0, 1, 1, 32'h10, 32'h1, 1);
        check("err_beats_clr", {31'h0, fsError}, 32'h1);
        step(1, 0, 1, 32'hFFFF_0001, 32'h0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Page discard through a metadata write
        step(0, 1, 0, 32'h0400, 32'hCAFEF00D, 0);
        step(0, 1, 1, 32'd1, 32'h80000005, 0);
        step(1, 0, 0, 32'h0400, 32'h0, 0);
        check("discard_data", fsQ, 32'h0);
        step(1, 0, 1, 32'd1, 32'h0, 0);
        check("discard_meta", fsQ, 32'h5);

        // Sessions
        repeat (3) pulse_access();
        check("session_3", {16'h0, sessionCount}, 32'd3);
        check_counters("directed");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 9);
            a = $urandom_range(0, 3) * 1024 + $urandom_range(0, 3);
            d = $urandom;
            case (kind)
                0, 1, 2: step(0, 1, 0, a, d, 0);
                3, 4, 5: begin
                    if (m_written[a / 1024] && !m_store.exists(a)) step(0, 1, 0, a, d, 0);
                    else step(1, 0, 0, a, 32'h0, 0);
                end
                6: step(0, 1, 1, $urandom_range(0, 15), d, 0);
                7: step(1, 0, 1, $urandom_range(0, 15), 32'h0, 0);
                8: begin
                    if ($urandom_range(0, 1) == 1)
                        step($urandom_range(0, 1) == 1, 0, 0, 32'h4000 + $urandom_range(0, 999), d, 0);
                    else
                        step(0, $urandom_range(0, 1) == 1, 1, 32'd16 + $urandom_range(0, 999), d, 0);
                    if (!fsWren) step(1, 0, 1, 32'd16 + $urandom_range(0, 5), 32'h0, $urandom_range(0, 1) == 1);
                end
                default: begin
                    if ($urandom_range(0, 2) == 0) step(1, 1, $urandom_range(0, 1) == 1, a, d, 0);
                    else step(0, 0, 0, a, d, $urandom_range(0, 1) == 1);
                end
            endcase
            if ($urandom_range(0, 31) == 0) pulse_access();
        end
        check_counters("random");

        // swapIns saturation
        for (int n = 0; n < 65536; n++) begin
            step(1, 0, 1, $urandom_range(0, 15), 32'h0, 0);
        end
        check("swapIns_sat", {16'h0, swapIns}, 32'h0000FFFF);
        step(1, 0, 1, 32'd3, 32'h0, 0);
        check("swapIns_nowrap", {16'h0, swapIns}, 32'h0000FFFF);
        check_counters("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
